// File: rtl/prj7620_seq.sv
// PAJ7620 bring-up and polling sequencer.
// Walks the shared mode bus through the phases WAKE -> DLY -> ID -> CFG -> POLL. Failures go to
// ERR, and init_start from IDLE or ERR begins a new pass.
// Ports:
//   i2c_clk     - sole clock
//   sys_rst     - synchronous active-high reset
//   init_start  - start/restart pulse, honoured in IDLE or ERR only
//   i2c_end     - transaction-end pulse from the I2C master
//   ack_err     - NACK flag, valid with i2c_end
//   rd_data     - read byte, valid with i2c_end
//   mode        - current phase code (0 IDLE,1 WAKE,2 DLY,3 ID,4 CFG,5 POLL,7 ERR)
//   cfg_start   - request the next configuration-table write (mode 4)
//   i2c_req     - request a transaction from the I2C master (modes 1, 3, 5)
//   init_done   - high while polling
//   err         - high while in ERR
//   gesture     - last nonzero gesture byte
//   gesture_vld - one-cycle pulse when gesture updates
module prj7620_seq #(
  parameter int unsigned WAKE_DLY  = 1000,
  parameter logic [7:0]  ID_VAL    = 8'h20,
  parameter int unsigned CFG_NUM   = 51,
  parameter int unsigned POLL_DLY  = 50000,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TO_CYC    = 4095
) (
  input  logic       i2c_clk,
  input  logic       sys_rst,
  input  logic       init_start,
  input  logic       i2c_end,
  input  logic       ack_err,
  input  logic [7:0] rd_data,
  output logic [2:0] mode,
  output logic       cfg_start,
  output logic       i2c_req,
  output logic       init_done,
  output logic       err,
  output logic [7:0] gesture,
  output logic       gesture_vld
);

  localparam int unsigned DlyW   = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;
  localparam int unsigned PollW  = (POLL_DLY > 1) ? $clog2(POLL_DLY) : 1;
  localparam int unsigned ToW    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWake = 3'd1,
    StDly  = 3'd2,
    StId   = 3'd3,
    StCfg  = 3'd4,
    StPoll = 3'd5,
    StErr  = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [5:0]          cfg_q, cfg_d;
  logic [DlyW-1:0]     dly_q, dly_d;
  logic [PollW-1:0]    poll_q, poll_d;
  logic [ToW-1:0]      to_q, to_d;
  logic                busy_q, busy_d;   // a transaction is outstanding
  logic                req_q, req_d;
  logic                cfg_start_q, cfg_start_d;
  logic                init_done_q, err_q;
  logic [7:0]          gesture_q, gesture_d;
  logic                gvld_q, gvld_d;
  logic                end_ok, timeout;

  // Completions only count while a request is outstanding.
  assign end_ok  = i2c_end && busy_q;
  assign timeout = busy_q && !i2c_end && (to_q == ToW'(TO_CYC - 1));

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    cfg_d       = cfg_q;
    dly_d       = dly_q;
    poll_d      = poll_q;
    to_d        = busy_q ? to_q + ToW'(1) : to_q;
    busy_d      = busy_q;
    req_d       = 1'b0;
    cfg_start_d = 1'b0;
    gesture_d   = gesture_q;
    gvld_d      = 1'b0;

    unique case (state_q)
      StIdle, StErr: begin
        if (init_start) begin
          state_d = StWake;
          retry_d = '0;
          cfg_d   = '0;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          to_d    = '0;
        end
      end
      StWake: begin
        // A NACK is normal while the sensor is still asleep.
        if (end_ok) begin
          state_d = StDly;
          busy_d  = 1'b0;
          dly_d   = '0;
        end
      end
      StDly: begin
        if (dly_q == DlyW'(WAKE_DLY - 1)) begin
          state_d = StId;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          to_d    = '0;
        end else begin
          dly_d = dly_q + DlyW'(1);
        end
      end
      StId: begin
        if (end_ok) begin
          busy_d = 1'b0;
          if (!ack_err && rd_data == ID_VAL) begin
            state_d     = StCfg;
            cfg_d       = '0;
            cfg_start_d = 1'b1;
            busy_d      = 1'b1;
            to_d        = '0;
          end else begin
            retry_d = retry_q + RetryW'(1);
            if (retry_d < RetryW'(MAX_RETRY)) begin
              state_d = StWake;
              req_d   = 1'b1;
              busy_d  = 1'b1;
              to_d    = '0;
            end else begin
              state_d = StErr;
            end
          end
        end
      end
      StCfg: begin
        if (end_ok) begin
          busy_d = 1'b0;
          cfg_d  = cfg_q + 6'd1;
          if (ack_err) begin
            state_d = StErr;
          end else if (cfg_d == 6'(CFG_NUM)) begin
            state_d = StPoll;
            poll_d  = '0;
          end else begin
            cfg_start_d = 1'b1;
            busy_d      = 1'b1;
            to_d        = '0;
          end
        end
      end
      StPoll: begin
        if (busy_q) begin
          // poll_q stays at 0 while the read is in flight.
          if (end_ok) begin
            busy_d = 1'b0;
            if (ack_err) begin
              state_d = StErr;
            end else if (rd_data != 8'h00) begin
              gesture_d = rd_data;
              gvld_d    = 1'b1;
            end
          end
        end else if (poll_q == PollW'(POLL_DLY - 1)) begin
          poll_d = '0;
          req_d  = 1'b1;
          busy_d = 1'b1;
          to_d   = '0;
        end else begin
          poll_d = poll_q + PollW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      state_d     = StErr;
      busy_d      = 1'b0;
      req_d       = 1'b0;
      cfg_start_d = 1'b0;
    end
  end

  always_ff @(posedge i2c_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      retry_q     <= '0;
      cfg_q       <= '0;
      dly_q       <= '0;
      poll_q      <= '0;
      to_q        <= '0;
      busy_q      <= 1'b0;
      req_q       <= 1'b0;
      cfg_start_q <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      gesture_q   <= 8'h00;
      gvld_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      cfg_q       <= cfg_d;
      dly_q       <= dly_d;
      poll_q      <= poll_d;
      to_q        <= to_d;
      busy_q      <= busy_d;
      req_q       <= req_d;
      cfg_start_q <= cfg_start_d;
      init_done_q <= (state_d == StPoll);
      err_q       <= (state_d == StErr);
      gesture_q   <= gesture_d;
      gvld_q      <= gvld_d;
    end
  end

  assign mode        = state_q;
  assign cfg_start   = cfg_start_q;
  assign i2c_req     = req_q;
  assign init_done   = init_done_q;
  assign err         = err_q;
  assign gesture     = gesture_q;
  assign gesture_vld = gvld_q;

endmodule

// File: doc/prj7620_seq.md
Name: prj7620_seq

Overview:
- Top-level sequencer for the PAJ7620 gesture sensor bring-up and run-time polling.
- Steps the shared `mode` bus through: wake-up, wake delay, ID check, 51-entry register configuration, then periodic gesture-register reads.
- Issues per-transaction start pulses:
  - `cfg_start` to the configuration table in mode 4.
  - `i2c_req` to the I2C master in all other transaction modes.
- Counts `i2c_end` completions, checks `ack_err` / `rd_data`, and reports `init_done`, `err` and gesture results.

Parameters:
- WAKE_DLY, 1000, `i2c_clk` cycles waited after the wake transaction.
- ID_VAL, 8'h20, expected value read from the sensor ID register in mode 3.
- CFG_NUM, 51, number of configuration writes in mode 4.
- POLL_DLY, 50000, `i2c_clk` cycles between gesture reads in mode 5.
- MAX_RETRY, 3, wake+ID attempts before declaring error.
- TO_CYC, 4095, watchdog limit in cycles from a request to its `i2c_end`.

Ports:
- i2c_clk, input, 1, sole clock.
- sys_rst, input, 1, synchronous active-high reset.
- init_start, input, 1, one-cycle pulse; honoured only in IDLE or ERR.
- i2c_end, input, 1, one-cycle pulse from the I2C master at transaction end.
- ack_err, input, 1, NACK flag; valid in the same cycle as `i2c_end`.
- rd_data, input, 8, read byte; valid in the same cycle as `i2c_end`.
- mode, output, 3, current phase: 0 IDLE, 1 WAKE, 2 DLY, 3 ID, 4 CFG, 5 POLL, 7 ERR.
- cfg_start, output, 1, one-cycle pulse requesting the next config write (mode 4 only).
- i2c_req, output, 1, one-cycle pulse requesting a transaction in modes 1, 3, 5.
- init_done, output, 1, high from entry to POLL until reset or restart.
- err, output, 1, high while in ERR.
- gesture, output, 8, last nonzero gesture byte.
- gesture_vld, output, 1, one-cycle pulse when `gesture` updates.

Behaviour:
- **Reset:** `sys_rst` sampled on the `i2c_clk` rising edge. It forces:
  - state IDLE, `mode`=0;
  - `cfg_start`, `i2c_req`, `init_done`, `err`, `gesture_vld` = 0;
  - `gesture`=8'h00;
  - all counters = 0.
  Reset mid-transaction abandons it; a late `i2c_end` is ignored.
- **Registered outputs:** `mode` is registered and equals the state code. A request pulse fires in the cycle after state entry, or after the triggering `i2c_end`.
- **IDLE:** `init_start` -> WAKE; `retry_cnt` cleared.
- **WAKE:** `i2c_req` pulse on entry. On `i2c_end` -> DLY. `ack_err` is ignored here, since a NACK while the sensor is asleep is expected.
- **DLY:** `dly_cnt` counts 0..WAKE_DLY-1, then -> ID. Exactly WAKE_DLY cycles are spent in mode 2.
- **ID:** `i2c_req` pulse on entry. On `i2c_end`:
  - `ack_err`=0 and `rd_data`==ID_VAL -> CFG.
  - Otherwise `retry_cnt`+1; if the new value < MAX_RETRY -> WAKE, else -> ERR.
- **CFG:**
  - `cfg_start` pulse on entry and after each `i2c_end` while `cfg_cnt` < CFG_NUM.
  - `cfg_cnt` (6 bit) increments on each `i2c_end`.
  - `ack_err` on any `i2c_end` -> ERR immediately; no further `cfg_start`.
  - The `i2c_end` that brings `cfg_cnt` to CFG_NUM -> POLL; no 52nd pulse.
  - Exactly CFG_NUM `cfg_start` pulses per pass.
- **POLL:**
  - `init_done`=1.
  - `poll_cnt` counts to POLL_DLY-1, then `i2c_req` pulse; `poll_cnt` holds at 0 until `i2c_end`.
  - On `i2c_end` with `ack_err`=0 and `rd_data`≠0: `gesture`<=`rd_data`, `gesture_vld` pulse in the next cycle.
  - `rd_data`==0: no update.
  - `ack_err` -> ERR.
- **Watchdog:** in WAKE, ID, CFG and POLL while a transaction is outstanding, `to_cnt` counts cycles since the request. Reaching TO_CYC without `i2c_end` -> ERR. `to_cnt` is cleared on each request.
- **ERR:**
  - `err`=1, `init_done`=0, `mode`=7.
  - `init_start` -> WAKE, clearing `err`, `retry_cnt` and `cfg_cnt`.
- **Ignored inputs:**
  - `init_start` in any state other than IDLE or ERR.
  - `i2c_end` when no transaction is outstanding.
- **Simultaneous events:** `sys_rst` has priority over everything.

Test Plan:
- **Full bring-up:** WAKE_DLY=10, POLL_DLY=20. Model acks all transactions, ID reads 8'h20. Pulse `init_start` -> `mode` walks 0,1,2,3,4,5; exactly 10 cycles in mode 2; 51 `cfg_start` pulses; `init_done`=1 on entering mode 5.
- **ID retry:** ID reads 8'h00 twice, then 8'h20 -> two WAKE→DLY→ID loops, then CFG. With all three reads wrong (MAX_RETRY=3) -> `mode`=7, `err`=1.
- **CFG NACK:** `ack_err`=1 on the 17th `i2c_end` in mode 4 -> ERR next cycle; 17 `cfg_start` pulses total. A subsequent `init_start` restarts at mode 1 with `err`=0.
- **Polling:** reads return 8'h00, 8'h01, 8'h00, 8'h40 -> `gesture_vld` pulses twice; `gesture`=8'h01 then 8'h40; `i2c_req` spacing equals 20 cycles plus transaction time.
- **Watchdog:** TO_CYC=100, withhold `i2c_end` after an ID request -> ERR at cycle 100.
- **Reset mid-CFG:** assert `sys_rst` at `cfg_cnt`=30 -> all outputs at reset values next edge. A stray `i2c_end` afterwards is ignored; `mode` stays 0.
